debugger_tx: RTL and testbench

Transmit stage of the MIPS debug unit. When the receive/command controller raises `sendSignal`, this block snapshots a wide pipeline-state word and streams it byte-by-byte into the UART transmit FIFO, honouring FIFO back-pressure. When the last byte is accepted it raises `dataSent`, which returns the command controller to its waiting state.

---
 rtl/debugger_tx.sv | 122 ++++++++++++
 tb/tb_debugger_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_tx.sv
// debugger_tx -- transmit stage of the MIPS debug unit.
//
// On a dump request the wide pipeline-state word is captured into a shift
// register and streamed, least-significant byte first, into the UART
// transmit FIFO at up to one byte per cycle. FIFO back-pressure (tx_full)
// stalls the stream without skipping or repeating bytes. When the last byte
// is accepted, dataSent rises and is held until the command controller drops
// its request, which prevents a held request from re-triggering a dump.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-low reset
//   sendSignal  dump request, held high until dataSent is seen
//   sendData    8*NUM_BYTES-bit pipeline-state word, captured at dump start
//   tx_full     UART transmit FIFO full
//   wr_uart     FIFO write strobe (combinational)
//   w_data      byte presented to the FIFO (combinational)
//   dataSent    dump complete (registered)
//   busy        dump in progress or awaiting handshake (registered)
module debugger_tx #(
  parameter int NUM_BYTES = 220
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sendSignal,
  input  logic [8*NUM_BYTES-1:0] sendData,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   dataSent,
  output logic                   busy
);

  localparam int            W    = 8 * NUM_BYTES;
  localparam int            CW   = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] byte_cnt, byte_cnt_nxt;
  logic          data_sent_nxt, busy_nxt;

  // NOTE: the wide shift register is an ordinary flop bank, not a RAM, so it
  // is cleared on reset; this keeps w_data at zero after reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      dataSent <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      byte_cnt <= byte_cnt_nxt;
      dataSent <= data_sent_nxt;
      busy     <= busy_nxt;
    end
  end

  // The FIFO strobe is gated by tx_full in the same cycle, so a byte offered
  // while the FIFO is full is simply re-offered next cycle.
  assign wr_uart = (state == SEND) && !tx_full;
  assign w_data  = shreg[7:0];

  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can infer a latch.
    state_nxt     = state;
    shreg_nxt     = shreg;
    byte_cnt_nxt  = byte_cnt;
    data_sent_nxt = dataSent;
    busy_nxt      = busy;

    case (state)
      IDLE: begin
        if (sendSignal) begin
          shreg_nxt    = sendData;
          byte_cnt_nxt = '0;
          busy_nxt     = 1'b1;
          state_nxt    = SEND;
        end
      end

      SEND: begin
        // sendSignal is ignored here: a started dump always runs to the end.
        if (wr_uart) begin
          shreg_nxt    = shreg >> 8;
          byte_cnt_nxt = byte_cnt + CW'(1);
          if (byte_cnt == LAST) begin
            data_sent_nxt = 1'b1;
            state_nxt     = DONE;
          end
        end
      end

      DONE: begin
        // Wait for the request to fall so a held request cannot retrigger.
        if (!sendSignal) begin
          data_sent_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        data_sent_nxt = 1'b0;
        busy_nxt      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debugger_tx.sv
// Testbench for debugger_tx: a 4-byte instance for the directed scenarios and
// a default-width (220-byte) instance for a randomized back-pressure dump.
// The reference model tracks the dump as "bytes delivered so far" and a
// completion flag, and compares the captured FIFO byte stream against the
// bytes of the request word taken low byte first.
module tb_debugger_tx;

  localparam int NB_S = 4;
  localparam int NB_L = 220;
  localparam int MAXW = 8 * NB_L;

  logic clock = 1'b0;
  logic reset;

  logic              sig_s, full_s, wr_s, ds_s, busy_s;
  logic [8*NB_S-1:0] data_s;
  logic [7:0]        wd_s;

  logic              sig_l, full_l, wr_l, ds_l, busy_l;
  logic [8*NB_L-1:0] data_l;
  logic [7:0]        wd_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  debugger_tx #(.NUM_BYTES(NB_S)) dut_s (
    .clock      (clock),
    .reset      (reset),
    .sendSignal (sig_s),
    .sendData   (data_s),
    .tx_full    (full_s),
    .wr_uart    (wr_s),
    .w_data     (wd_s),
    .dataSent   (ds_s),
    .busy       (busy_s)
  );

  debugger_tx #(.NUM_BYTES(NB_L)) dut_l (
    .clock      (clock),
    .reset      (reset),
    .sendSignal (sig_l),
    .sendData   (data_l),
    .tx_full    (full_l),
    .wr_uart    (wr_l),
    .w_data     (wd_l),
    .dataSent   (ds_l),
    .busy       (busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic sig, input logic full,
                       input logic [MAXW-1:0] data);
    if (which == 0) begin
      sig_s  = sig;
      full_s = full;
      data_s = data[8*NB_S-1:0];
    end else begin
      sig_l  = sig;
      full_l = full;
      data_l = data;
    end
  endtask

  task automatic sample(input int which, output logic wr, output logic [7:0] wd,
                        output logic ds, output logic bz);
    if (which == 0) begin
      wr = wr_s; wd = wd_s; ds = ds_s; bz = busy_s;
    end else begin
      wr = wr_l; wd = wd_l; ds = ds_l; bz = busy_l;
    end
  endtask

  // One complete request/handshake. Inputs change 1 time unit after the
  // rising edge and outputs are sampled 1 unit later, well away from the edge.
  //   stall_from/stall_len : tx_full high in cycles stall_from+1..+stall_len
  //   rand_full            : random tx_full instead of the scripted window
  //   hold                 : DONE cycles during which the request stays high
  //   change_data          : request word zeroed from cycle 2 on
  //   drop_early           : request dropped from cycle 2 on (during SEND)
  //   reset_at             : reset pulled low in this cycle (0 = never)
  task automatic run_dump(input string tag, input int which, input logic [MAXW-1:0] data,
                          input int stall_from, input int stall_len, input bit rand_full,
                          input int hold, input bit change_data, input bit drop_early,
                          input int reset_at);
    int nb, sent, done_cnt, mism;
    bit done, prev_wr, prev_sig, finished, aborted;
    logic [7:0] expq[$];
    logic [7:0] got[$];
    logic [MAXW-1:0] cur;
    logic sig, full, wr, ds, bz, exp_wr;
    logic [7:0] wd;

    nb = (which == 0) ? NB_S : NB_L;
    for (int i = 0; i < nb; i++) expq.push_back(data[8*i +: 8]);

    // Cycle 0: raise the request while the block is idle.
    @(posedge clock); #1;
    drive(which, 1'b1, 1'b0, data);
    #1;
    sample(which, wr, wd, ds, bz);
    check({tag, "/idle_wr"}, 32'(wr), 32'd0);
    check({tag, "/idle_busy"}, 32'(bz), 32'd0);

    sent = 0; done = 0; prev_wr = 0; prev_sig = 1; done_cnt = 0;
    finished = 0; aborted = 0; cur = data;

    for (int c = 1; c <= 800 && !finished && !aborted; c++) begin
      @(posedge clock); #1;

      if (reset_at != 0 && c == reset_at + 1) begin
        reset = 1'b1;
        drive(which, 1'b0, 1'b0, cur);
        #1;
        sample(which, wr, wd, ds, bz);
        check({tag, "/rst_wr"}, 32'(wr), 32'd0);
        check({tag, "/rst_busy"}, 32'(bz), 32'd0);
        check({tag, "/rst_ds"}, 32'(ds), 32'd0);
        check({tag, "/rst_wdata"}, 32'(wd), 32'd0);
        aborted = 1;
      end else begin
        if (done && !prev_sig) finished = 1;
        if (prev_wr) begin
          sent++;
          if (sent == nb) done = 1;
        end

        if (finished) begin
          drive(which, 1'b0, 1'b0, cur);
          #1;
          sample(which, wr, wd, ds, bz);
          check({tag, "/end_wr"}, 32'(wr), 32'd0);
          check({tag, "/end_ds"}, 32'(ds), 32'd0);
          check({tag, "/end_busy"}, 32'(bz), 32'd0);
        end else begin
          if (drop_early && c >= 2) sig = 1'b0;
          else if (!done)           sig = 1'b1;
          else                      sig = (done_cnt < hold);
          if (rand_full) full = ($urandom_range(0, 2) == 0);
          else           full = (c > stall_from) && (c <= stall_from + stall_len);
          if (change_data && c >= 2) cur = '0;
          if (reset_at != 0 && c == reset_at) reset = 1'b0;
          drive(which, sig, full, cur);
          #1;
          sample(which, wr, wd, ds, bz);
          exp_wr = !done && !full;
          check($sformatf("%s/c%0d_wr", tag, c), 32'(wr), 32'(exp_wr));
          check($sformatf("%s/c%0d_ds", tag, c), 32'(ds), 32'(done));
          check($sformatf("%s/c%0d_busy", tag, c), 32'(bz), 32'd1);
          if (wr === 1'b1 && c != reset_at) got.push_back(wd);
          prev_wr  = exp_wr && (c != reset_at);
          prev_sig = sig;
          if (done) done_cnt++;
        end
      end
    end

    if (!finished && !aborted) check({tag, "/timeout"}, 32'd1, 32'd0);

    check({tag, "/byte_count"}, 32'(got.size()), 32'(aborted ? sent : nb));
    mism = 0;
    for (int i = 0; i < got.size() && i < nb; i++) begin
      if (nb <= 8) check($sformatf("%s/byte%0d", tag, i), 32'(got[i]), 32'(expq[i]));
      else if (got[i] !== expq[i]) mism++;
    end
    if (nb > 8) check({tag, "/byte_mismatches"}, 32'(mism), 32'd0);
  endtask

  initial begin
    logic [MAXW-1:0] d;
    logic wr, ds, bz;
    logic [7:0] wd;

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clock);
    #1;
    for (int w = 0; w < 2; w++) begin
      sample(w, wr, wd, ds, bz);
      check($sformatf("reset%0d/wr", w), 32'(wr), 32'd0);
      check($sformatf("reset%0d/wdata", w), 32'(wd), 32'd0);
      check($sformatf("reset%0d/ds", w), 32'(ds), 32'd0);
      check($sformatf("reset%0d/busy", w), 32'(bz), 32'd0);
    end
    reset = 1'b1;

    d = '0;
    d[31:0] = 32'hA1B2C3D4;
    run_dump("basic", 0, d, 0, 0, 0, 1, 0, 0, 0);
    run_dump("stall", 0, d, 2, 3, 0, 1, 0, 0, 0);
    run_dump("hold", 0, d, 0, 0, 0, 6, 0, 0, 0);
    run_dump("retrigger", 0, d, 0, 0, 0, 1, 0, 0, 0);
    run_dump("midchange", 0, d, 0, 0, 0, 1, 1, 0, 0);
    run_dump("reset_mid", 0, d, 0, 0, 0, 1, 0, 0, 3);
    run_dump("after_reset", 0, d, 0, 0, 0, 1, 0, 0, 0);
    run_dump("drop_early", 0, d, 1, 1, 0, 1, 0, 1, 0);

    for (int k = 0; k < 6; k++) begin
      d = '0;
      d[31:0] = $urandom();
      run_dump($sformatf("rand%0d", k), 0, d, 0, 0, 1, $urandom_range(0, 3), 0, 0, 0);
    end

    for (int i = 0; i < NB_L; i++) d[8*i +: 8] = 8'(i);
    run_dump("wide", 1, d, 0, 0, 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
